// File: rtl/usb_sie_rx_pkt_buffer_pkg.sv
// Shared definitions for the SIE receive packet buffer.
//   config_pkg   : default sizing of the buffer
//   sie_defs_pkg : receive-side FSM state encoding
package config_pkg;
  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 64;
  localparam int unsigned DEFAULT_CNT_W  = 8;
endpackage

package sie_defs_pkg;
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_FILL = 2'd1,
    RX_DROP = 2'd2
  } rxState_t;
endpackage

// File: rtl/usb_sie_buf_ram.sv
// Packet storage: one synchronous write port, one asynchronous read port.
// Contents are not reset.
//   clk12_i : write clock
//   wrEn    : write strobe, wrAddr / wrData : write address and entry
//   rdAddr  : read address, rdData : entry at rdAddr (combinational)
module usb_sie_buf_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 9,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk12_i,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk12_i) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/usb_sie_rx_pkt_buffer.sv
// Receive packet buffer between the SIE rx path and the endpoint consumer.
// Bytes are written speculatively; a packet becomes visible to the reader
// only when its last byte arrives with keep set. Bad or overflowing packets
// are rolled back and counted.
//   clk12_i, rst_n_i            : clock, async active-low reset
//   flush_i                     : discard everything, stored and in flight
//   in_valid_i/in_data_i/in_last_i/in_keep_i, in_ready_o : byte input
//   out_valid_o/out_data_o/out_last_o, out_ready_i       : committed bytes
//   pkt_avail_o                 : committed packets not yet fully read
//   drop_pulse_o, drop_cnt_o    : discarded-packet pulse and saturating count
module usb_sie_rx_pkt_buffer
  import config_pkg::*;
  import sie_defs_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic                     clk12_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic                     in_last_i,
  input  logic                     in_keep_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   pkt_avail_o,
  output logic                     drop_pulse_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = DATA_W + 1;

  rxState_t           rxState;
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   commitPtr;
  logic [PTR_W-1:0]   specPtr;
  logic [PTR_W-1:0]   usedCnt;
  logic [PTR_W-1:0]   pktAvail;
  logic [CNT_W-1:0]   dropCnt;
  logic               inReadyQ;
  logic               dropPulse;
  logic               full;
  logic               accept;
  logic               rdFire;
  logic               lastRead;
  logic               wrEn;
  logic               commitEvt;
  logic               dropEvt;
  logic [ENTRY_W-1:0] rdEntry;

  // Occupancy counts speculative bytes too, so a packet can never overwrite
  // unread committed data.
  assign usedCnt  = specPtr - rdPtr;
  assign full     = (usedCnt == PTR_W'(DEPTH));

  assign in_ready_o = inReadyQ & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  assign out_valid_o = (rdPtr != commitPtr);
  assign rdFire      = out_valid_o & out_ready_i & ~flush_i;
  assign lastRead    = rdFire & rdEntry[DATA_W];
  assign out_data_o  = rdEntry[DATA_W-1:0];
  assign out_last_o  = rdEntry[DATA_W];

  assign pkt_avail_o  = pktAvail;
  assign drop_pulse_o = dropPulse;
  assign drop_cnt_o   = dropCnt;

  // Byte classification for the current cycle: write, commit or discard.
  always_comb begin
    wrEn      = 1'b0;
    commitEvt = 1'b0;
    dropEvt   = 1'b0;
    if (accept) begin
      if (rxState == RX_DROP) begin
        dropEvt = in_last_i;
      end else if (full) begin
        // Overflow on a last byte ends the packet immediately.
        dropEvt = in_last_i;
      end else if (in_last_i) begin
        wrEn      = in_keep_i;
        commitEvt = in_keep_i;
        dropEvt   = ~in_keep_i;
      end else begin
        wrEn = 1'b1;
      end
    end
  end

  // Receive FSM, pointers and status counters.
  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rxState   <= RX_IDLE;
      rdPtr     <= '0;
      commitPtr <= '0;
      specPtr   <= '0;
      pktAvail  <= '0;
      dropCnt   <= '0;
      inReadyQ  <= 1'b0;
      dropPulse <= 1'b0;
    end else begin
      inReadyQ  <= 1'b1;
      dropPulse <= dropEvt;
      if (dropEvt && (dropCnt != {CNT_W{1'b1}})) dropCnt <= dropCnt + CNT_W'(1);

      if (flush_i) begin
        rxState   <= RX_IDLE;
        rdPtr     <= '0;
        commitPtr <= '0;
        specPtr   <= '0;
        pktAvail  <= '0;
      end else begin
        if (rdFire) rdPtr <= rdPtr + PTR_W'(1);

        // Commit and final-byte read in one cycle cancel out.
        case ({commitEvt, lastRead})
          2'b10:   pktAvail <= pktAvail + PTR_W'(1);
          2'b01:   pktAvail <= pktAvail - PTR_W'(1);
          default: pktAvail <= pktAvail;
        endcase

        if (accept) begin
          case (rxState)
            RX_IDLE, RX_FILL: begin
              if (full) begin
                specPtr <= commitPtr;
                rxState <= in_last_i ? RX_IDLE : RX_DROP;
              end else if (in_last_i) begin
                if (in_keep_i) begin
                  specPtr   <= specPtr + PTR_W'(1);
                  commitPtr <= specPtr + PTR_W'(1);
                end else begin
                  specPtr <= commitPtr;
                end
                rxState <= RX_IDLE;
              end else begin
                specPtr <= specPtr + PTR_W'(1);
                rxState <= RX_FILL;
              end
            end
            RX_DROP: begin
              if (in_last_i) rxState <= RX_IDLE;
            end
            default: rxState <= RX_IDLE;
          endcase
        end
      end
    end
  end

  usb_sie_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk12_i (clk12_i),
    .wrEn    (wrEn),
    .wrAddr  (specPtr[ADDR_W-1:0]),
    .wrData  ({in_last_i, in_data_i}),
    .rdAddr  (rdPtr[ADDR_W-1:0]),
    .rdData  (rdEntry)
  );

endmodule

// File: tb/tb_usb_sie_rx_pkt_buffer.sv
// Scoreboard bench for usb_sie_rx_pkt_buffer (DEPTH=4, CNT_W=2).
// The driver pushes every byte of a packet expected to be delivered; a
// negedge monitor pops and compares on each accepted output byte.
module tb_usb_sie_rx_pkt_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned PW     = $clog2(DEPTH) + 1;

  logic              clk12_i;
  logic              rst_n_i;
  logic              flush_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_last_i;
  logic              in_keep_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;
  logic              out_ready_i;
  logic [PW-1:0]     pkt_avail_o;
  logic              drop_pulse_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  logic [DATA_W:0] sb[$];
  int nCmp = 0;
  int nBad = 0;
  int pulseCnt = 0;
  int expPulse = 0;
  int readyMode = 0;

  usb_sie_rx_pkt_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk12_i      (clk12_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .in_keep_i    (in_keep_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i),
    .pkt_avail_o  (pkt_avail_o),
    .drop_pulse_o (drop_pulse_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  initial begin
    clk12_i = 1'b0;
    forever #5 clk12_i = ~clk12_i;
  end

  // Consumer ready: 0 = hold low, 1 = hold high, 2 = random 50%.
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk12_i);
      #1;
      if (readyMode == 2) out_ready_i = 1'($urandom_range(0, 1));
      else                out_ready_i = (readyMode == 1);
    end
  end

  // Monitor: pop and compare on every byte the consumer takes.
  always @(negedge clk12_i) begin
    logic [DATA_W:0] expE;
    if (rst_n_i) begin
      if (drop_pulse_o === 1'b1) pulseCnt++;
      if (out_valid_o && out_ready_i && !flush_i) begin
        nCmp++;
        if (sb.size() == 0) begin
          nBad++;
          $display("FAIL unexpected_out: got last=%0b data=%02h, required no output",
                   out_last_o, out_data_o);
        end else begin
          expE = sb.pop_front();
          if ({out_last_o, out_data_o} !== expE) begin
            nBad++;
            $display("FAIL out_byte: got last=%0b data=%02h, required last=%0b data=%02h",
                     out_last_o, out_data_o, expE[DATA_W], expE[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expV);
    nCmp++;
    if (act != expV) begin
      nBad++;
      $display("FAIL %s: got %0d, required %0d", name, act, expV);
    end
  endtask

  task automatic sendByte(input logic [DATA_W-1:0] d, input logic last,
                          input logic keep, input logic expOut);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    in_keep_i  = keep;
    if (expOut) sb.push_back({last, d});
    @(posedge clk12_i);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_keep_i  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    readyMode = 1;
    while ((sb.size() != 0 || out_valid_o) && n < 300) begin
      @(posedge clk12_i);
      #1;
      n++;
    end
    check(name, int'(sb.size() == 0 && !out_valid_o), 1);
    readyMode = 0;
    repeat (2) @(posedge clk12_i);
    #1;
  endtask

  task automatic doReset();
    rst_n_i = 1'b0;
    #1;
    check("rst_in_ready",   int'(in_ready_o),   0);
    check("rst_out_valid",  int'(out_valid_o),  0);
    check("rst_pkt_avail",  int'(pkt_avail_o),  0);
    check("rst_drop_pulse", int'(drop_pulse_o), 0);
    check("rst_drop_cnt",   int'(drop_cnt_o),   0);
    sb.delete();
    repeat (2) @(posedge clk12_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk12_i);
    #1;
    check("post_rst_in_ready", int'(in_ready_o), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    rst_n_i    = 1'b1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_last_i  = 1'b0;
    in_keep_i  = 1'b0;
    #2;
    doReset();

    // Basic 3-byte good packet; commit latency and pkt_avail 1 -> 0.
    sendByte(8'hC3, 1'b0, 1'b0, 1'b1);
    sendByte(8'h11, 1'b0, 1'b0, 1'b1);
    @(negedge clk12_i);
    check("uncommitted_hidden", int'(out_valid_o), 0);
    sendByte(8'h22, 1'b1, 1'b1, 1'b1);
    @(negedge clk12_i);
    check("commit_latency", int'(out_valid_o), 1);
    check("pkt_avail_one", int'(pkt_avail_o), 1);
    drain("drain_basic");
    check("pkt_avail_zero", int'(pkt_avail_o), 0);

    // Bad packet followed by a good one.
    readyMode = 1;
    sendByte(8'hAA, 1'b0, 1'b0, 1'b0);
    sendByte(8'hBB, 1'b0, 1'b0, 1'b0);
    sendByte(8'hCC, 1'b1, 1'b0, 1'b0);
    expPulse++;
    sendByte(8'h01, 1'b0, 1'b0, 1'b1);
    sendByte(8'h02, 1'b1, 1'b1, 1'b1);
    drain("drain_bad_good");
    check("drop_cnt_bad", int'(drop_cnt_o), 1);
    check("pulses_bad", pulseCnt, expPulse);

    // Reset in the middle of a packet: lost silently.
    sendByte(8'h77, 1'b0, 1'b0, 1'b0);
    sendByte(8'h88, 1'b0, 1'b0, 1'b0);
    doReset();
    check("pulses_mid_reset", pulseCnt, expPulse);

    // Overflow: 6-byte packet into 4 entries, then a 2-byte packet.
    for (int j = 0; j < 6; j++) sendByte(8'(8'h60 + j), 1'(j == 5), 1'b1, 1'b0);
    expPulse++;
    repeat (2) @(posedge clk12_i);
    @(negedge clk12_i);
    check("ovf_no_output", int'(out_valid_o), 0);
    check("ovf_pkt_avail", int'(pkt_avail_o), 0);
    check("ovf_drop_cnt", int'(drop_cnt_o), 1);
    check("ovf_pulses", pulseCnt, expPulse);
    sendByte(8'h5A, 1'b0, 1'b0, 1'b1);
    sendByte(8'hA5, 1'b1, 1'b1, 1'b1);
    drain("drain_after_ovf");
    check("ovf_after_pkt_avail", int'(pkt_avail_o), 0);

    // Continuous stream of 20 packets with random consumer stalls.
    readyMode = 2;
    for (int p = 0; p < 20; p++) begin
      len = 1 + (p % 3);
      n = 0;
      while (sb.size() + len > DEPTH && n < 200) begin
        @(posedge clk12_i);
        #1;
        n++;
      end
      if (n >= 200) check("stream_space_timeout", n, 0);
      for (int j = 0; j < len; j++)
        sendByte(8'(p * 16 + j), 1'(j == len - 1), 1'b1, 1'b1);
    end
    drain("drain_stream");
    check("stream_pkt_avail", int'(pkt_avail_o), 0);
    check("stream_drop_cnt", int'(drop_cnt_o), 1);
    check("stream_pulses", pulseCnt, expPulse);

    // Flush with one committed packet pending and one in flight.
    sendByte(8'h31, 1'b0, 1'b0, 1'b1);
    sendByte(8'h32, 1'b1, 1'b1, 1'b1);
    sendByte(8'h41, 1'b0, 1'b0, 1'b0);
    sendByte(8'h42, 1'b0, 1'b0, 1'b0);
    check("pre_flush_pkt_avail", int'(pkt_avail_o), 1);
    flush_i = 1'b1;
    #1;
    check("flush_in_ready", int'(in_ready_o), 0);
    @(posedge clk12_i);
    #1;
    flush_i = 1'b0;
    sb.delete();
    @(negedge clk12_i);
    check("flush_out_valid", int'(out_valid_o), 0);
    check("flush_pkt_avail", int'(pkt_avail_o), 0);
    check("flush_drop_cnt", int'(drop_cnt_o), 1);
    check("flush_in_ready_back", int'(in_ready_o), 1);
    @(posedge clk12_i);
    #1;
    sendByte(8'h55, 1'b1, 1'b1, 1'b1);
    drain("drain_after_flush");
    check("flush_pulses", pulseCnt, expPulse);

    // Saturation: five bad packets into a 2-bit counter.
    doReset();
    readyMode = 1;
    for (int k = 0; k < 5; k++) begin
      sendByte(8'(8'h90 + k), 1'b0, 1'b0, 1'b0);
      sendByte(8'(8'hA0 + k), 1'b1, 1'b0, 1'b0);
      expPulse++;
    end
    repeat (3) @(posedge clk12_i);
    @(negedge clk12_i);
    check("sat_drop_cnt", int'(drop_cnt_o), 3);
    check("sat_pulses", pulseCnt, expPulse);
    check("sat_no_output", int'(out_valid_o), 0);
    readyMode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/usb_sie_rx_pkt_buffer.md
USB_SIE_RX_PKT_BUFFER -- requirements
Module: usb_sie_rx_pkt_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of the stored payload.
REQ-002 SHALL have parameter DEPTH, default 64, entry count, power of two, 4..1024.
REQ-003 SHALL have parameter CNT_W, default 8, width of the drop counter.
REQ-004 SHALL have port clk12_i  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  discard all stored and in-flight data.
REQ-007 SHALL have port in_valid_i  input  1  byte from SIE rx side valid.
REQ-008 SHALL have port in_data_i  input  DATA_W  received byte.
REQ-009 SHALL have port in_last_i  input  1  byte is last of packet.
REQ-010 SHALL have port in_keep_i  input  1  packet good (CRC/bitstuff ok); sampled only with in_last_i.
REQ-011 SHALL have port in_ready_o  output  1  buffer accepts a byte.
REQ-012 SHALL have port out_valid_o  output  1  committed byte available.
REQ-013 SHALL have port out_data_o  output  DATA_W  committed byte.
REQ-014 SHALL have port out_last_o  output  1  out_data_o ends its packet.
REQ-015 SHALL have port out_ready_i  input  1  consumer takes byte.
REQ-016 SHALL have port pkt_avail_o  output  $clog2(DEPTH)+1  committed packets not fully read.
REQ-017 SHALL have port drop_pulse_o  output  1  one-cycle pulse per discarded packet.
REQ-018 SHALL have port drop_cnt_o  output  CNT_W  saturating discarded-packet count.

Function
REQ-019 SHALL store {last, data} per entry; pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)), wrap modulo 2*DEPTH.
REQ-020 SHALL keep three pointers: rd_ptr, commit_ptr, spec_ptr; free = DEPTH-(spec_ptr-rd_ptr).
REQ-021 SHALL accept a byte on in_valid_i && in_ready_o, writing at spec_ptr, spec_ptr+1.
REQ-022 SHALL drive in_ready_o=1 whenever out of reset and not flushing; bytes are never back-pressured, only dropped.
REQ-023 SHALL run rx FSM states IDLE, FILL, DROP.
REQ-024 IDLE->FILL on accepted non-last byte with free>0; accepted last byte in IDLE treated as single-byte packet.
REQ-025 In FILL/IDLE, accepted last byte with keep=1 and free>0: write it, commit_ptr<=spec_ptr+1, pkt_avail+1, ->IDLE.
REQ-026 Accepted last byte with keep=0: spec_ptr<=commit_ptr, drop pulse, ->IDLE.
REQ-027 Accepted byte with free==0: spec_ptr<=commit_ptr, ->DROP (overflow); no write.
REQ-028 DROP: swallow bytes; on accepted last byte emit drop pulse, ->IDLE regardless of keep.
REQ-029 out_valid_o = (rd_ptr != commit_ptr); out_data_o/out_last_o from entry at rd_ptr (asynchronous read).
REQ-030 Committed byte SHALL appear on out_valid_o the cycle after the commit edge (latency 1).
REQ-031 On out_valid_o && out_ready_i: rd_ptr+1; if out_last_o, pkt_avail-1.
REQ-032 Commit and final-byte read in the same cycle SHALL leave pkt_avail unchanged (net 0).
REQ-033 Read and write in the same cycle SHALL both occur; free computed from pre-edge pointers.
REQ-034 drop_cnt_o SHALL increment per drop pulse, saturate at 2^CNT_W-1.
REQ-035 flush_i SHALL set all pointers to 0, pkt_avail 0, FSM IDLE, in_ready_o 0 that cycle; drop_cnt_o unchanged; a packet in flight is silently discarded (no pulse).

Reset
REQ-036 On rst_n_i low, asynchronously: pointers 0, FSM IDLE, in_ready_o 0, out_valid_o 0, pkt_avail_o 0, drop_pulse_o 0, drop_cnt_o 0.
REQ-037 Storage array SHALL not be reset; out_data_o/out_last_o undefined while out_valid_o=0.
REQ-038 Reset mid-packet SHALL lose the packet without drop pulse.

Structure
REQ-039 rx FSM state enum SHALL live in sie_defs_pkg; DEPTH/DATA_W defaults in config_pkg.
REQ-040 Storage SHALL be a sub-module usb_sie_buf_ram (1 write port, 1 async read port, parametrised DEPTH/width).

Verification
REQ-041 Bytes 0xC3,0x11,0x22(last,keep=1) -> out 0xC3,0x11,0x22 with out_last on 0x22, pkt_avail 1->0.
REQ-042 3-byte packet ending keep=0, then 2-byte packet keep=1 -> only second packet read; drop_pulse once; drop_cnt 1.
REQ-043 DEPTH=4, 6-byte packet keep=1 -> no output, drop_cnt 1; following 2-byte packet delivered intact.
REQ-044 Continuous stream, 20 packets, out_ready_i random 50% -> byte order preserved, pointer wrap past 2*DEPTH correct.
REQ-045 flush_i mid-packet with one committed packet pending -> out_valid 0 next cycle, pkt_avail 0, drop_cnt unchanged.
REQ-046 CNT_W=2, 5 bad packets -> drop_cnt_o holds 3.
